// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters, with burst capping.
// Optional stall watchdog enabled by defining MUX_ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
  output logic            busy
`ifdef MUX_ARB_TIMEOUT_EN
  ,
  output logic            timeout_err
`endif
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_beat_cnt, w_beat_cnt_nxt;

  logic [1:0] w_pick;
  logic       w_found;
  logic       w_valid;
  logic       w_beat;
  logic       w_last_beat;
  logic       w_timeout;
  logic       w_release;

  assign w_valid     = (r_state == GRANT) & req[r_sel];
  assign w_beat      = w_valid & out_ready;
  assign w_last_beat = w_beat & (r_beat_cnt == LAST_BEAT);
  assign w_release   = (r_state == GRANT) & (~req[r_sel] | w_last_beat | w_timeout);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int SW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

  logic [SW-1:0] r_stall_cnt, w_stall_cnt_nxt;
  logic          r_timeout_err;
  logic          w_stall;

  assign w_stall         = w_valid & ~out_ready;
  assign w_timeout       = w_stall & (r_stall_cnt == STALL_LAST);
  assign w_stall_cnt_nxt = (w_stall & ~w_release) ? r_stall_cnt + SW'(1) : '0;

  // The error flag is registered off the release edge, so it pulses during the bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_timeout_err <= w_timeout;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

  // Rotating priority: first requester after the last-granted index, wrapping back to it.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && req[2'(r_ptr + 2'(i))]) begin
        w_pick  = 2'(r_ptr + 2'(i));
        w_found = 1'b1;
      end
    end
  end

  // NOTE: every next-state signal is defaulted to its current value first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_sel_nxt      = r_sel;
    w_ptr_nxt      = r_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt    = GRANT;
          w_sel_nxt      = w_pick;
          w_gnt_nxt      = 4'b0001 << w_pick;
          w_beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nxt    = IDLE;
          w_gnt_nxt      = '0;
          w_ptr_nxt      = r_sel;
          w_beat_cnt_nxt = '0;
        end else if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together
  // from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_ptr      <= 2'd3;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign busy      = (r_state == GRANT);
  assign out_valid = w_valid;
  assign out_data  = in_data[r_sel*DW +: DW];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed table-driven bench for mux4_rr_arbiter; one row per clock cycle, plus
// hand-written stall sequences (timeout variant when MUX_ARB_TIMEOUT_EN is defined).
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] in_data;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
`ifdef MUX_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  mux4_rr_arbiter #(.DW(8), .MAX_BURST(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef MUX_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lane_val(input logic [1:0] s);
    case (s)
      2'd0: return 8'h11;
      2'd1: return 8'h22;
      2'd2: return 8'h33;
      default: return 8'h44;
    endcase
  endfunction

  task automatic add(input logic r, input logic [3:0] q, input logic rd,
                     input logic [3:0] g, input logic [1:0] s, input logic v, input logic b);
    vec_t e;
    e.rst_n = r; e.req = q; e.rdy = rd; e.gnt = g; e.sel = s; e.valid = v; e.busy = b;
    vecs.push_back(e);
  endtask

  task automatic burst(input logic [3:0] q, input logic [3:0] g, input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) add(1'b1, q, 1'b1, g, s, 1'b1, 1'b1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};

    // Reset and idle
    add(0, 4'h0, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 4'h0, 0, 4'h0, 0, 0, 0);
    // Lone lane 0: four beats, bubble, regrant with a two-cycle stall inside the burst
    add(1, 4'h1, 1, 4'h0, 0, 0, 0);
    burst(4'h1, 4'h1, 0, 4);
    add(1, 4'h1, 1, 4'h0, 0, 0, 0);
    burst(4'h1, 4'h1, 0, 1);
    add(1, 4'h1, 0, 4'h1, 0, 1, 1);
    add(1, 4'h1, 0, 4'h1, 0, 1, 1);
    burst(4'h1, 4'h1, 0, 3);
    add(1, 4'h0, 1, 4'h0, 0, 0, 0);
    // Reset restores ptr=3; all four requesting rotate 0,1,2,3,0
    add(0, 4'h0, 0, 4'h0, 0, 0, 0);
    add(1, 4'hF, 1, 4'h0, 0, 0, 0);
    burst(4'hF, 4'h1, 0, 4); add(1, 4'hF, 1, 4'h0, 0, 0, 0);
    burst(4'hF, 4'h2, 1, 4); add(1, 4'hF, 1, 4'h0, 1, 0, 0);
    burst(4'hF, 4'h4, 2, 4); add(1, 4'hF, 1, 4'h0, 2, 0, 0);
    burst(4'hF, 4'h8, 3, 4); add(1, 4'hF, 1, 4'h0, 3, 0, 0);
    burst(4'hF, 4'h1, 0, 4); add(1, 4'h4, 1, 4'h0, 0, 0, 0);
    // Lane 2 drops after two beats with lane 3 waiting
    burst(4'h4, 4'h4, 2, 2);
    add(1, 4'h8, 1, 4'h4, 2, 0, 1);
    add(1, 4'h8, 1, 4'h0, 2, 0, 0);
    add(1, 4'h8, 0, 4'h8, 3, 1, 1);
    add(1, 4'h0, 1, 4'h8, 3, 0, 1);
    add(1, 4'h1, 1, 4'h0, 3, 0, 0);
    // Lane 0 granted, lane 2 waits; then lane 2 drops with only lane 0 waiting (wrap)
    burst(4'h5, 4'h1, 0, 1);
    add(1, 4'h4, 1, 4'h1, 0, 0, 1);
    add(1, 4'h4, 1, 4'h0, 0, 0, 0);
    burst(4'h4, 4'h4, 2, 2);
    add(1, 4'h1, 1, 4'h4, 2, 0, 1);
    add(1, 4'h1, 1, 4'h0, 2, 0, 0);
    burst(4'h3, 4'h1, 0, 1);
    // Reset asserted mid-burst on lane 1
    add(1, 4'h2, 1, 4'h1, 0, 0, 1);
    add(1, 4'h2, 1, 4'h0, 0, 0, 0);
    burst(4'h2, 4'h2, 1, 1);
    add(0, 4'h2, 1, 4'h0, 0, 0, 0);
    add(0, 4'h6, 1, 4'h0, 0, 0, 0);
    add(1, 4'h6, 1, 4'h0, 0, 0, 0);
    burst(4'h6, 4'h2, 1, 1);

    next_cycle();
    next_cycle();
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n     = vecs[i].rst_n;
      req       = vecs[i].req;
      out_ready = vecs[i].rdy;
      #1;
      check($sformatf("row%0d gnt", i), {28'd0, gnt}, {28'd0, vecs[i].gnt});
      check($sformatf("row%0d sel", i), {30'd0, sel}, {30'd0, vecs[i].sel});
      check($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].valid});
      check($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      check($sformatf("row%0d out_data", i), {24'd0, out_data}, {24'd0, lane_val(vecs[i].sel)});
      next_cycle();
    end

    // Stalled downstream on lane 0 with lane 1 waiting
    rst_n = 1'b0; req = 4'h0; out_ready = 1'b0;
    next_cycle();
    rst_n = 1'b1; req = 4'h3;
    #1;
    check("stall idle gnt", {28'd0, gnt}, 32'h0);
    next_cycle();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("stall%0d gnt", i), {28'd0, gnt}, 32'h1);
`ifdef MUX_ARB_TIMEOUT_EN
      check($sformatf("stall%0d timeout_err", i), {31'd0, timeout_err}, 32'h0);
`endif
      next_cycle();
    end
`ifdef MUX_ARB_TIMEOUT_EN
    check("timeout release gnt", {28'd0, gnt}, 32'h0);
    check("timeout release busy", {31'd0, busy}, 32'h0);
    check("timeout pulse", {31'd0, timeout_err}, 32'h1);
    next_cycle();
    check("after timeout gnt", {28'd0, gnt}, 32'h2);
    check("after timeout sel", {30'd0, sel}, 32'h1);
    check("timeout pulse end", {31'd0, timeout_err}, 32'h0);
`else
    for (int i = 0; i < 8; i++) begin
      check($sformatf("hold%0d gnt", i), {28'd0, gnt}, 32'h1);
      check($sformatf("hold%0d out_valid", i), {31'd0, out_valid}, 32'h1);
      next_cycle();
    end
    out_ready = 1'b1;
    #1;
    check("unstall data", {24'd0, out_data}, 32'h11);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
